// File: rtl/router_pkg.sv
// Shared types and constants for the router output arbiter slice.
package router_pkg;

  localparam int PORT_W  = 2;
  localparam int NPORTS  = 3;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // (p + k) mod 3, for port rotation
  function automatic logic [PORT_W-1:0] port_add(input logic [PORT_W-1:0] p,
                                                 input int unsigned k);
    int unsigned s;
    s = (32'(p) + k) % 32'(NPORTS);
    return PORT_W'(s);
  endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// FIFO-side and egress-side signals of the output arbiter, bundled with modports.
interface router_out_arbiter_if
  import router_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic [DATA_W-1:0] fifo_dout_0;
  logic [DATA_W-1:0] fifo_dout_1;
  logic [DATA_W-1:0] fifo_dout_2;
  logic              read_enb_0;
  logic              read_enb_1;
  logic              read_enb_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;
  logic [DATA_W-1:0] data_out;
  logic              vld_out;
  logic              ready_in;
  logic [PORT_W-1:0] grant;
  logic              busy;
  logic              pkt_done;

  modport master (
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  fifo_dout_0, fifo_dout_1, fifo_dout_2,
    input  ready_in,
    output read_enb_0, read_enb_1, read_enb_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output data_out, vld_out, grant, busy, pkt_done
  );

  modport slave (
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output fifo_dout_0, fifo_dout_1, fifo_dout_2,
    output ready_in,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  data_out, vld_out, grant, busy, pkt_done
  );

endinterface

// File: rtl/router_rr_pick.sv
// Round-robin port picker: first non-empty port in order ptr+1, ptr+2, ptr.
module router_rr_pick
  import router_pkg::*;
(
  input  logic [PORT_W-1:0] i_ptr,
  input  logic [NPORTS-1:0] i_nonempty,
  output logic [PORT_W-1:0] o_port,
  output logic              o_found
);

  logic [PORT_W-1:0] w_idx;

  // Walk the order backwards so the highest-priority candidate is written last
  always_comb begin
    o_port  = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      w_idx = port_add(i_ptr, k);
      if (i_nonempty[w_idx]) begin
        o_port  = w_idx;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Packet-granular round-robin scheduler sharing one egress link among three
// router FIFOs, with a stall timeout that aborts the packet and clears its FIFO.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
)(
  input  logic                 clock,
  input  logic                 resetn,
  router_out_arbiter_if.master bus
);

  localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              r_state;
  logic [PORT_W-1:0]   r_ptr;
  logic [PORT_W-1:0]   r_grant;
  logic [LEN_W-1:0]    r_cnt;
  logic [SW-1:0]       r_stall;
  logic [DATA_W-1:0]   r_data_p0;
  logic                r_vld_p0;
  logic [NPORTS-1:0]   r_soft;

  logic [NPORTS-1:0]   w_empty;
  logic [DATA_W-1:0]   w_head;
  logic [PORT_W-1:0]   w_pick;
  logic                w_found;
  logic                w_xfer;
  logic                w_load;
  logic                w_accept;
  logic                w_stall;
  logic                w_abort;
  logic [LEN_W-1:0]    w_len;
  logic [NPORTS-1:0]   w_rd;

  assign w_empty = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};

  always_comb begin
    case (r_grant)
      2'd1:    w_head = bus.fifo_dout_1;
      2'd2:    w_head = bus.fifo_dout_2;
      default: w_head = bus.fifo_dout_0;
    endcase
  end

  router_rr_pick u_pick (
    .i_ptr      (r_ptr),
    .i_nonempty (~w_empty),
    .o_port     (w_pick),
    .o_found    (w_found)
  );

  assign w_xfer   = (r_state == ST_HDR) || (r_state == ST_PAYLOAD) || (r_state == ST_PARITY);
  // Gated by resetn so a FIFO never loses a byte on the reset edge
  assign w_load   = resetn && (!r_vld_p0 || bus.ready_in) && !w_empty[r_grant] && w_xfer;
  assign w_accept = r_vld_p0 && bus.ready_in;
  assign w_stall  = r_vld_p0 && !bus.ready_in;
  assign w_abort  = w_stall && (r_stall == SW'(TIMEOUT - 1));
  assign w_len    = w_head[LEN_MSB:LEN_LSB];
  assign w_rd     = w_load ? (NPORTS'(1) << r_grant) : '0;

  // Stage p0: FSM, counters and egress register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_ptr     <= PORT_W'(2);
      r_grant   <= '0;
      r_cnt     <= '0;
      r_stall   <= '0;
      r_data_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_soft    <= '0;
    end else begin
      r_soft  <= '0;
      r_stall <= (w_abort || !w_stall) ? '0 : r_stall + 1'b1;
      if (w_abort) begin
        r_soft   <= NPORTS'(1) << r_grant;
        r_vld_p0 <= 1'b0;
        r_ptr    <= r_grant;
        r_state  <= ST_IDLE;
      end else begin
        if (w_load) begin
          r_data_p0 <= w_head;
          r_vld_p0  <= 1'b1;
        end else if (w_accept) begin
          r_vld_p0  <= 1'b0;
        end
        case (r_state)
          ST_IDLE: begin
            if (w_found) begin
              r_grant <= w_pick;
              r_state <= ST_HDR;
            end
          end
          ST_HDR: begin
            if (w_load) begin
              r_cnt   <= w_len;
              r_state <= (w_len == '0) ? ST_PARITY : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (w_load) begin
              r_cnt <= r_cnt - 1'b1;
              if (r_cnt == LEN_W'(1)) r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            if (w_load) r_state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (w_accept) begin
              r_ptr   <= r_grant;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.read_enb_0   = w_rd[0];
  assign bus.read_enb_1   = w_rd[1];
  assign bus.read_enb_2   = w_rd[2];
  assign bus.soft_reset_0 = r_soft[0];
  assign bus.soft_reset_1 = r_soft[1];
  assign bus.soft_reset_2 = r_soft[2];
  assign bus.data_out     = r_data_p0;
  assign bus.vld_out      = r_vld_p0;
  assign bus.grant        = r_grant;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.pkt_done     = (r_state == ST_DRAIN) && w_accept;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: FIFO model, table-driven single packets, hand sequences.
module tb_router_out_arbiter;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 30;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_out_arbiter_if #(.DATA_W(DATA_W)) bus ();

  router_out_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int             port;
    logic [7:0]     hdr;
    logic [2:0][7:0] pay;
    int             npay;
    logic [7:0]     par;
    int             exp_bytes;
    int             exp_grant;
  } vec_t;

  logic [7:0] q0[$], q1[$], q2[$];
  logic [7:0] stream[$];
  logic [1:0] done_grant[$];
  logic [2:0] pend_rd, pend_clr;
  logic       rst_req, ready_req;
  int n_checks = 0, n_errors = 0;
  int cyc, first_rd, first_vld, last_vld, n_done, multi_rd;
  int n_soft[3], n_rd[3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_stream(input string name, input logic [7:0] exp[$]);
    int bad;
    bad = (stream.size() != exp.size()) ? 1 : 0;
    for (int i = 0; i < exp.size() && i < stream.size(); i++)
      if (stream[i] != exp[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic drive();
    bus.fifo_empty_0 = (q0.size() == 0);
    bus.fifo_empty_1 = (q1.size() == 0);
    bus.fifo_empty_2 = (q2.size() == 0);
    bus.fifo_dout_0  = (q0.size() != 0) ? q0[0] : 8'h00;
    bus.fifo_dout_1  = (q1.size() != 0) ? q1[0] : 8'h00;
    bus.fifo_dout_2  = (q2.size() != 0) ? q2[0] : 8'h00;
  endtask

  task automatic push(input int p, input logic [7:0] b);
    case (p)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic push_pkt(input int p, input logic [7:0] hdr, input logic [2:0][7:0] pay,
                          input int npay, input logic [7:0] par);
    push(p, hdr);
    for (int i = 0; i < npay; i++) push(p, pay[i]);
    push(p, par);
  endtask

  task automatic clear_log();
    stream.delete();
    done_grant.delete();
    cyc = 0; first_rd = -1; first_vld = -1; last_vld = -1; n_done = 0;
    for (int i = 0; i < 3; i++) begin n_soft[i] = 0; n_rd[i] = 0; end
  endtask

  // One clock: apply last cycle's pops/clears, drive inputs, sample mid-cycle
  task automatic cycle();
    logic [2:0] rd, sr;
    @(negedge clock);
    if (pend_rd[0] && q0.size() != 0) void'(q0.pop_front());
    if (pend_rd[1] && q1.size() != 0) void'(q1.pop_front());
    if (pend_rd[2] && q2.size() != 0) void'(q2.pop_front());
    if (pend_clr[0]) q0.delete();
    if (pend_clr[1]) q1.delete();
    if (pend_clr[2]) q2.delete();
    resetn = rst_req;
    bus.ready_in = ready_req;
    drive();
    #1;
    rd = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    sr = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    if ($countones(rd) > 1) multi_rd++;
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin n_rd[i]++; if (first_rd < 0) first_rd = cyc; end
      if (sr[i]) n_soft[i]++;
    end
    if (bus.vld_out) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
    end
    if (bus.vld_out && bus.ready_in) stream.push_back(bus.data_out);
    if (bus.pkt_done) begin n_done++; done_grant.push_back(bus.grant); end
    pend_rd = rd;
    pend_clr = sr;
    cyc++;
  endtask

  task automatic run_until_done(input string name, input int target, input int maxc);
    int k = 0;
    while (n_done < target && k < maxc) begin cycle(); k++; end
    chk(name, n_done, target);
    cycle(); cycle();
  endtask

  task automatic run_until_byte(input string name, input logic [7:0] b, input int maxc);
    int k = 0;
    logic hit = 1'b0;
    while (!hit && k < maxc) begin
      cycle(); k++;
      hit = bus.vld_out && bus.ready_in && (bus.data_out == b);
    end
    chk(name, int'(hit), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    logic [7:0] exp[$];
    int unstable, soft_at, vld_at_soft;

    tbl[0] = '{1, 8'h0D, {8'hA3, 8'hA2, 8'hA1}, 3, 8'h5F, 5, 1};
    tbl[1] = '{0, 8'h04, {8'h00, 8'h00, 8'h77}, 1, 8'h73, 3, 0};
    tbl[2] = '{2, 8'h00, {8'h00, 8'h00, 8'h00}, 0, 8'h3C, 2, 2};

    multi_rd = 0; pend_rd = '0; pend_clr = '0;
    rst_req = 1'b0; ready_req = 1'b1;
    resetn = 1'b0; bus.ready_in = 1'b1;
    drive();
    clear_log();

    // Reset state
    cycle(); cycle();
    chk("rst_vld", int'(bus.vld_out), 0);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_data", int'(bus.data_out), 0);
    chk("rst_done", int'(bus.pkt_done), 0);
    chk("rst_soft", int'({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}), 0);
    rst_req = 1'b1;

    // Single packets from the table
    for (int t = 0; t < 3; t++) begin
      clear_log();
      push_pkt(tbl[t].port, tbl[t].hdr, tbl[t].pay, tbl[t].npay, tbl[t].par);
      exp.delete();
      exp.push_back(tbl[t].hdr);
      for (int i = 0; i < tbl[t].npay; i++) exp.push_back(tbl[t].pay[i]);
      exp.push_back(tbl[t].par);
      run_until_done($sformatf("t%0d_done_wait", t), 1, 40);
      chk($sformatf("t%0d_nbytes", t), stream.size(), tbl[t].exp_bytes);
      chk_stream($sformatf("t%0d_stream", t), exp);
      chk($sformatf("t%0d_grant", t), int'(done_grant.size() > 0 ? done_grant[0] : 2'd3), tbl[t].exp_grant);
      chk($sformatf("t%0d_rd_cnt", t), n_rd[tbl[t].port], tbl[t].exp_bytes);
      chk($sformatf("t%0d_first_rd", t), first_rd, 1);
      chk($sformatf("t%0d_first_vld", t), first_vld, 2);
      chk($sformatf("t%0d_span", t), last_vld - first_vld + 1, tbl[t].exp_bytes);
      chk($sformatf("t%0d_busy_after", t), int'(bus.busy), 0);
    end

    // Round robin across three ports, port 0 re-served after port 2
    clear_log();
    push_pkt(0, 8'h04, {8'h00, 8'h00, 8'h10}, 1, 8'h14);
    push_pkt(0, 8'h04, {8'h00, 8'h00, 8'h40}, 1, 8'h44);
    push_pkt(1, 8'h04, {8'h00, 8'h00, 8'h20}, 1, 8'h24);
    push_pkt(2, 8'h04, {8'h00, 8'h00, 8'h30}, 1, 8'h34);
    run_until_done("rr_done_wait", 4, 80);
    chk("rr_ndone", done_grant.size(), 4);
    if (done_grant.size() == 4) begin
      chk("rr_g0", int'(done_grant[0]), 0);
      chk("rr_g1", int'(done_grant[1]), 1);
      chk("rr_g2", int'(done_grant[2]), 2);
      chk("rr_g3", int'(done_grant[3]), 0);
    end
    exp = '{8'h04, 8'h10, 8'h14, 8'h04, 8'h20, 8'h24, 8'h04, 8'h30, 8'h34, 8'h04, 8'h40, 8'h44};
    chk_stream("rr_stream", exp);

    // Stall for TIMEOUT-1 cycles mid-payload: no abort, data held
    clear_log();
    push_pkt(1, 8'h0C, {8'hB3, 8'hB2, 8'hB1}, 3, 8'hBF);
    run_until_byte("st_find_b1", 8'hB1, 20);
    unstable = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      ready_req = 1'b0;
      cycle();
      if (!(bus.vld_out && bus.data_out == 8'hB2)) unstable++;
    end
    ready_req = 1'b1;
    run_until_done("st_done_wait", 1, 20);
    chk("st_hold", unstable, 0);
    chk("st_soft", n_soft[0] + n_soft[1] + n_soft[2], 0);
    exp = '{8'h0C, 8'hB1, 8'hB2, 8'hB3, 8'hBF};
    chk_stream("st_stream", exp);

    // Stall for TIMEOUT cycles on port 0: abort, then port 1 served
    clear_log();
    push_pkt(0, 8'h0C, {8'hC3, 8'hC2, 8'hC1}, 3, 8'hCF);
    push_pkt(1, 8'h04, {8'h00, 8'h00, 8'hD1}, 1, 8'hDF);
    run_until_byte("ab_find_c1", 8'hC1, 20);
    soft_at = -1; vld_at_soft = -1;
    for (int i = 0; i <= TIMEOUT; i++) begin
      ready_req = (i < TIMEOUT) ? 1'b0 : 1'b1;
      cycle();
      if (bus.soft_reset_0 && soft_at < 0) begin
        soft_at = i;
        vld_at_soft = int'(bus.vld_out);
      end
    end
    ready_req = 1'b1;
    run_until_done("ab_done_wait", 1, 30);
    chk("ab_soft_time", soft_at, TIMEOUT);
    chk("ab_vld_drop", vld_at_soft, 0);
    chk("ab_soft0_cnt", n_soft[0], 1);
    chk("ab_soft12_cnt", n_soft[1] + n_soft[2], 0);
    chk("ab_next_grant", int'(done_grant.size() > 0 ? done_grant[0] : 2'd3), 1);
    exp = '{8'h0C, 8'hC1, 8'h04, 8'hD1, 8'hDF};
    chk_stream("ab_stream", exp);

    // Reset pulse during payload
    clear_log();
    push_pkt(2, 8'h0C, {8'hE3, 8'hE2, 8'hE1}, 3, 8'hEF);
    run_until_byte("rs_find_e1", 8'hE1, 20);
    rst_req = 1'b0;
    cycle();
    rst_req = 1'b1;
    cycle();
    chk("rs_vld", int'(bus.vld_out), 0);
    chk("rs_busy", int'(bus.busy), 0);
    chk("rs_grant", int'(bus.grant), 0);
    chk("rs_rd", int'({bus.read_enb_2, bus.read_enb_1, bus.read_enb_0}), 0);
    chk("rs_soft", n_soft[0] + n_soft[1] + n_soft[2], 0);
    chk("rs_fifo_left", int'(q2.size() > 0), 1);

    chk("one_hot_rd", multi_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Packet-granular round-robin scheduler that shares one downstream output link among the router's three output FIFOs. It pops whole packets (header, payload, parity) from one granted FIFO into a registered valid/ready output stage. It aborts a packet stalled by the consumer for TIMEOUT cycles by pulsing that FIFO's soft reset. It sits between the three router FIFOs and the single egress port.

## Interface
- DATA_W, 8: byte width; header length field is bits [7:2].
- TIMEOUT, 30: consecutive stalled cycles before abort; minimum 2.
- clock  in  1  rising-edge clock.
- resetn  in  1  reset, synchronous, active-low.
- fifo_empty_0/1/2  in  1 each  FIFO empty flag.
- fifo_dout_0/1/2  in  DATA_W each  FIFO head data, first-word-fall-through (valid whenever not empty).
- read_enb_0/1/2  out  1 each  pop strobe; combinational; at most one high per cycle.
- soft_reset_0/1/2  out  1 each  registered one-cycle FIFO clear on timeout.
- data_out  out  DATA_W  registered egress byte.
- vld_out  out  1  data_out valid.
- ready_in  in  1  consumer accepts data_out when vld_out && ready_in.
- grant  out  2  port currently or last served; 0..2.
- busy  out  1  high in every state except IDLE.
- pkt_done  out  1  one-cycle pulse when a packet's parity byte is accepted.

## Operation
- States: IDLE, HDR, PAYLOAD, PARITY, DRAIN.
- load = (!vld_out || ready_in) && !fifo_empty[grant] && state in {HDR, PAYLOAD, PARITY}. On load: read_enb[grant]=1, data_out<=fifo_dout[grant], vld_out<=1.
- Accept without load: vld_out<=0.
- IDLE: pick the first non-empty port in order ptr+1, ptr+2, ptr (mod 3). Register grant, go to HDR. No pick if all empty.
- HDR load: cnt<=dout[7:2]. If 0 go to PARITY, else go to PAYLOAD.
- PAYLOAD load: cnt<=cnt-1. The load with cnt==1 goes to PARITY.
- PARITY load: go to DRAIN.
- DRAIN: on accept, pkt_done=1, ptr<=grant, go to IDLE.
- FIFO empty mid-packet: no pop, no error. The block waits indefinitely; the starvation wait does not count toward timeout.
- Stall counter: increments while vld_out && !ready_in, clears otherwise.
- Abort: when the stall counter reaches TIMEOUT-1 and the stall persists, the next cycle does all of the following:
  - soft_reset[grant]=1.
  - vld_out<=0 (byte dropped).
  - ptr<=grant.
  - state<=IDLE.
  - no pkt_done.
- 2-port or 1-port traffic: the rotation skips empty ports; a single active port is re-granted back-to-back.

## Timing
- Reset values:
  - state=IDLE, ptr=2 (port 0 has first priority).
  - grant=0, data_out=0, vld_out=0.
  - soft_reset_*=0, pkt_done=0, busy=0, cnt=0, stall counter=0.
- read_enb_* are 0 whenever state is IDLE.
- Latency: a non-empty FIFO seen in IDLE at cycle 0 gives read_enb at cycle 1 and vld_out=1 at cycle 2.
- Streaming with ready_in held high: one byte per cycle.
  - A packet of length L occupies L+2 load cycles.
  - IDLE is revisited for one cycle between packets.
- soft_reset asserts exactly TIMEOUT cycles after the first stalled cycle.
- Reset mid-packet: all state clears next edge, no soft_reset is issued, and a partial FIFO packet remains.

## Structure
- Shared package router_pkg holds:
  - the state enum;
  - PORT_W=2;
  - the header length field bounds LEN_MSB=7, LEN_LSB=2.
- One combinational sub-module, router_rr_pick: inputs ptr and a 3-bit non-empty vector; outputs the chosen port and a found flag.
- Everything else is inline: FSM, counters, output register.

## Test plan
- Port 1 holds header 0x0D (length 3), bytes A1 A2 A3, parity 5F; ready_in=1. Required response:
  - 5 bytes on consecutive cycles;
  - read_enb_1 high for 5 cycles;
  - pkt_done once;
  - grant=1.
- All three FIFOs hold one length-1 packet. Required response: order 0, 1, 2; next packet on port 0 served after port 2.
- Zero-length header 0x00 on port 2. Required response: header then parity only, i.e. 2 bytes and pkt_done.
- Hold ready_in low for TIMEOUT-1 cycles mid-payload, then release. Required response:
  - no soft_reset;
  - data_out held stable through the stall;
  - packet completes intact.
- Hold ready_in low for TIMEOUT cycles on port 0. Required response:
  - soft_reset_0 pulses once;
  - vld_out drops;
  - next grant goes to port 1 if it is pending.
- Assert resetn=0 for one cycle during PAYLOAD. Required response: vld_out=0, busy=0, grant=0 next cycle; no read_enb and no soft_reset pulses.
